// File: rtl/fir_sm_out_stage_if.sv
// Stream bundle between the FIR MAC datapath, the output stage and the
// downstream AXI-Stream consumer. The output stage uses the master view.
interface fir_sm_out_stage_if #(
  parameter int pDATA_WIDTH = 32
);
  // Core -> stage sample handshake
  logic                   y_valid;
  logic [pDATA_WIDTH-1:0] y_data;
  logic                   y_ready;
  // Stage -> downstream AXI-Stream beat
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    input  y_valid, y_data, sm_tready,
    output y_ready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    output y_valid, y_data, sm_tready,
    input  y_ready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_sm_out_stage.sv
// FIR output stage: buffers filtered samples in a small circular FIFO,
// streams them out as AXI-Stream beats with tlast on the final beat of a
// frame, and pulses done once the whole frame has been accepted downstream.
module fir_sm_out_stage #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int pLEN_WIDTH  = 32
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  start,
  input  logic [pLEN_WIDTH-1:0] data_length,
  output logic                  busy,
  output logic                  done,
  fir_sm_out_stage_if.master    bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [pLEN_WIDTH-1:0] LEN_ONE  = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]      PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]        CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]        CNT_FULL = DEPTH[PTR_W:0];

  logic [1:0]             state_reg, state_next;
  logic [pLEN_WIDTH-1:0]  len_reg, len_next;
  logic [pLEN_WIDTH-1:0]  in_cnt_reg, in_cnt_next;
  logic [pLEN_WIDTH-1:0]  out_cnt_reg, out_cnt_next;
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]         count_reg;
  logic [pDATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]       wr_en;

  logic fifo_empty, fifo_full;
  logic push, pop, last_in, last_out;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_FULL);

  // No pass-through path: a full FIFO refuses input even while popping.
  assign bus.y_ready   = (state_reg == S_RUN) & ~fifo_full & (in_cnt_reg < len_reg);
  assign bus.sm_tvalid = ~fifo_empty;
  // Data is forced to zero while nothing is buffered so reset shows all-zero outputs.
  assign bus.sm_tdata  = fifo_empty ? '0 : mem_reg[rd_ptr_reg];
  assign bus.sm_tlast  = ~fifo_empty & (out_cnt_reg == len_reg - LEN_ONE);

  assign push     = bus.y_valid & bus.y_ready;
  assign pop      = bus.sm_tvalid & bus.sm_tready;
  assign last_in  = push & ((in_cnt_reg + LEN_ONE) == len_reg);
  assign last_out = pop & bus.sm_tlast;

  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_FIN);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Frame sequencing and beat counters; a start outside IDLE is ignored.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    in_cnt_next  = push ? in_cnt_reg + LEN_ONE : in_cnt_reg;
    out_cnt_next = pop ? out_cnt_reg + LEN_ONE : out_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          len_next     = data_length;
          in_cnt_next  = '0;
          out_cnt_next = '0;
          state_next   = (data_length == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (last_out)     state_next = S_FIN;
        else if (last_in) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_out) state_next = S_FIN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state, pointers and occupancy; reset discards buffered samples.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_reg   <= S_IDLE;
      len_reg     <= '0;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      in_cnt_reg  <= in_cnt_next;
      out_cnt_reg <= out_cnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sample storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge axis_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= bus.y_data;
    end
  end

endmodule
